// File: rtl/sample_tick_gen.sv
// sample_tick_gen: programmable-divisor sample tick with rotating sample index and one-hot channel select.
// Latency: all outputs registered; tick/index/frame_wrap change on the terminal edge, div_ack on the edge a divisor lands.
// Backpressure: none; en stalls counting. Optional macro SAMPLE_SYNC_EN adds sync_in frame re-alignment.
module sample_tick_gen #(
    parameter int CNT_W       = 26,
    parameter int DIV_DEFAULT = 50000,
    parameter int SEL_W       = 2,
    parameter int NCH         = 4
) (
    input  logic             clk,
    input  logic             rst_m,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
`ifdef SAMPLE_SYNC_EN
    input  logic             sync_in,
`endif
    output logic             div_ack,
    output logic             tick,
    output logic [SEL_W-1:0] sample_idx,
    output logic [NCH-1:0]   chan_sel,
    output logic             frame_wrap
);

    localparam logic [NCH-1:0] SEL_ONE = NCH'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [NCH-1:0]   sel_q, sel_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             ack_q, ack_d;
    logic             terminal;

    assign terminal = en && (cnt_q == div_q);

`ifdef SAMPLE_SYNC_EN
    logic sync_meta_q, sync_q, sync_prev_q;
    logic sync_edge;

    always_ff @(posedge clk or posedge rst_m) begin
        if (rst_m) begin
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
            sync_prev_q <= 1'b0;
        end else begin
            sync_meta_q <= sync_in;
            sync_q      <= sync_meta_q;
            sync_prev_q <= sync_q;
        end
    end

    assign sync_edge = sync_q && !sync_prev_q;
`endif

    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        idx_d      = idx_q;
        sel_d      = sel_q;
        tick_d     = 1'b0;
        wrap_d     = 1'b0;
        ack_d      = 1'b0;

        if (en) begin
            if (terminal) begin
                cnt_d  = '0;
                idx_d  = idx_q + SEL_W'(1);
                sel_d  = SEL_ONE << idx_d;
                tick_d = 1'b1;
                wrap_d = (idx_q == SEL_W'(NCH - 1));
                // The terminal just taken used the old divisor, so the swap never shortens a period.
                if (pend_q) begin
                    div_d  = pend_val_q;
                    pend_d = 1'b0;
                    ack_d  = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pend_q) begin
            div_d  = pend_val_q;
            cnt_d  = '0;
            pend_d = 1'b0;
            ack_d  = 1'b1;
        end

        // A load arriving with an application edge becomes the next pending value.
        if (div_load) begin
            pend_val_d = div_in;
            pend_d     = 1'b1;
        end

`ifdef SAMPLE_SYNC_EN
        if (sync_edge) begin
            cnt_d  = '0;
            idx_d  = '0;
            sel_d  = SEL_ONE;
            tick_d = 1'b0;
            wrap_d = 1'b1;
            div_d  = div_q;
            pend_d = pend_q || div_load;
            ack_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst_m) begin
        if (rst_m) begin
            cnt_q      <= '0;
            div_q      <= CNT_W'(DIV_DEFAULT);
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            idx_q      <= '0;
            sel_q      <= SEL_ONE;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            tick_q     <= tick_d;
            wrap_q     <= wrap_d;
            ack_q      <= ack_d;
        end
    end

    assign div_ack    = ack_q;
    assign tick       = tick_q;
    assign sample_idx = idx_q;
    assign chan_sel   = sel_q;
    assign frame_wrap = wrap_q;

endmodule

// File: tb/tb_sample_tick_gen.sv
// Bench for sample_tick_gen with DIV_DEFAULT=3: vector table, hand-written corner sequences,
// then random en/load traffic against a tick-counting reference model.
module tb_sample_tick_gen;

    localparam int CNT_W   = 26;
    localparam int SEL_W   = 2;
    localparam int NCH     = 4;
    localparam int DIV_DEF = 3;

    logic             clk = 1'b0;
    logic             rst_m = 1'b1;
    logic             en = 1'b0;
    logic             div_load = 1'b0;
    logic [CNT_W-1:0] div_in = '0;
    logic             div_ack, tick, frame_wrap;
    logic [SEL_W-1:0] sample_idx;
    logic [NCH-1:0]   chan_sel;
`ifdef SAMPLE_SYNC_EN
    logic             sync_in = 1'b0;
`endif

    sample_tick_gen #(
        .CNT_W(CNT_W), .DIV_DEFAULT(DIV_DEF), .SEL_W(SEL_W), .NCH(NCH)
    ) dut (
        .clk(clk),
        .rst_m(rst_m),
        .en(en),
        .div_in(div_in),
        .div_load(div_load),
`ifdef SAMPLE_SYNC_EN
        .sync_in(sync_in),
`endif
        .div_ack(div_ack),
        .tick(tick),
        .sample_idx(sample_idx),
        .chan_sel(chan_sel),
        .frame_wrap(frame_wrap)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic             en;
        logic             ld;
        logic [CNT_W-1:0] din;
        logic             tick;
        logic [SEL_W-1:0] idx;
        logic [NCH-1:0]   sel;
        logic             wrap;
        logic             ack;
    } vec_t;

    vec_t tbl[$];

    // Reference: period is div+1 enabled cycles; idx/select/wrap follow from the total tick count.
    int m_pos, m_div, m_pval, m_ticks;
    bit m_pend, m_tick, m_ack;

    function automatic logic [NCH-1:0] onehot(input int i);
        logic [NCH-1:0] one;
        one = 1;
        return one << i;
    endfunction

    function automatic void add(input logic e, input logic l, input int d, input logic t,
                                input int i, input logic w, input logic a);
        vec_t v;
        v.en = e; v.ld = l; v.din = CNT_W'(d); v.tick = t;
        v.idx = SEL_W'(i); v.sel = onehot(i); v.wrap = w; v.ack = a;
        tbl.push_back(v);
    endfunction

    task automatic model_reset();
        m_pos = 0; m_div = DIV_DEF; m_pval = 0; m_ticks = 0;
        m_pend = 0; m_tick = 0; m_ack = 0;
    endtask

    task automatic model_step(input logic e, input logic l, input int d);
        m_tick = 0;
        m_ack  = 0;
        if (e) begin
            if (m_pos == m_div) begin
                m_pos = 0;
                m_ticks++;
                m_tick = 1;
                if (m_pend) begin m_div = m_pval; m_pend = 0; m_ack = 1; end
            end else begin
                m_pos++;
            end
        end else if (m_pend) begin
            m_div = m_pval; m_pos = 0; m_pend = 0; m_ack = 1;
        end
        if (l) begin m_pval = d; m_pend = 1; end
    endtask

    task automatic check(input string name, input logic e_tick, input logic [SEL_W-1:0] e_idx,
                         input logic [NCH-1:0] e_sel, input logic e_wrap, input logic e_ack);
        vectors++;
        if ({tick, sample_idx, chan_sel, frame_wrap, div_ack} !== {e_tick, e_idx, e_sel, e_wrap, e_ack}) begin
            miscompares++;
            $display("FAIL %s: got tick=%b idx=%0d sel=%b wrap=%b ack=%b, want tick=%b idx=%0d sel=%b wrap=%b ack=%b",
                     name, tick, sample_idx, chan_sel, frame_wrap, div_ack,
                     e_tick, e_idx, e_sel, e_wrap, e_ack);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic check_model(input string name);
        int i;
        i = m_ticks % NCH;
        check(name, m_tick, SEL_W'(i), onehot(i), m_tick && (i == 0), m_ack);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic e, input logic l, input int d);
        en = e; div_load = l; div_in = CNT_W'(d);
        @(posedge clk);
        model_step(e, l, d);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_m = 1'b1; en = 1'b0; div_load = 1'b0; div_in = '0;
        @(negedge clk);
        rst_m = 1'b0;
        model_reset();
    endtask

    // Steps with en=1 until tick, returns the number of edges taken and acks seen.
    task automatic run_to_tick(output int n, output int acks);
        n = 0;
        acks = 0;
        do begin
            step(1, 0, 0);
            n++;
            acks += int'(div_ack);
        end while (!tick && n < 40);
    endtask

    initial begin
        int n, acks;
        logic e, l;
        int d;

        // Free run, div=3: ticks every 4th edge, wrap only on 3->0.
        for (int s = 1; s <= 4; s++) begin
            for (int k = 0; k < 3; k++) add(1, 0, 0, 0, s - 1, 0, 0);
            add(1, 0, 0, 1, s % NCH, s == 4, 0);
        end
        // en gap at cnt=2, then resume.
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) add(0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0, 0);
        // Load div=1 mid-period: current period stays 4, then 2.
        add(1, 1, 1, 0, 1, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 1, 2, 0, 1);
        add(1, 0, 0, 0, 2, 0, 0);
        add(1, 0, 0, 1, 3, 0, 0);
        add(1, 0, 0, 0, 3, 0, 0);
        add(1, 0, 0, 1, 0, 1, 0);

        model_reset();
        @(negedge clk);
        check("reset_state", 0, 0, onehot(0), 0, 0);
        rst_m = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].ld, int'(tbl[i].din));
            check($sformatf("vec%0d", i), tbl[i].tick, tbl[i].idx, tbl[i].sel, tbl[i].wrap, tbl[i].ack);
        end

        // Two loads before the terminal: one ack, last value (7) wins.
        do_reset();
        step(1, 1, 5);
        check("t4_load1", 0, 0, onehot(0), 0, 0);
        step(1, 1, 7);
        step(1, 0, 0);
        step(1, 0, 0);
        check("t4_apply", 1, 1, onehot(1), 0, 1);
        run_to_tick(n, acks);
        check_int("t4_period8", n, 8);
        check_int("t4_single_ack", acks, 0);
        // Load while idle: applied on the next edge with cnt cleared.
        step(0, 1, 2);
        check("t4_idle_load", 0, 2, onehot(2), 0, 0);
        step(0, 0, 0);
        check("t4_idle_ack", 0, 2, onehot(2), 0, 1);
        run_to_tick(n, acks);
        check_int("t4_period_after_idle", n, 3);

        // div=0: tick every enabled cycle.
        step(1, 1, 0);
        check_model("t5_load");
        for (int k = 0; k < 2; k++) begin
            step(1, 0, 0);
            check_model("t5_drain");
        end
        for (int k = 0; k < 6; k++) begin
            step(1, 0, 0);
            check_model("t5_every_cycle");
            check_int("t5_tick_high", int'(tick), 1);
        end

        // Async reset mid-period with a pending load: discarded, no ack.
        do_reset();
        for (int k = 0; k < 5; k++) step(1, 0, 0);
        step(1, 1, 0);
        check_model("t6_pre_reset");
        #2 rst_m = 1'b1;
        #1 check("t6_async_reset", 0, 0, onehot(0), 0, 0);
        @(negedge clk);
        rst_m = 1'b0;
        model_reset();
        for (int k = 0; k < 8; k++) begin
            step(1, 0, 0);
            check_model("t6_after_reset");
        end

`ifdef SAMPLE_SYNC_EN
        // Sync edge lands on the 3rd edge and beats a coincident terminal.
        do_reset();
        for (int k = 0; k < 5; k++) step(1, 0, 0);
        sync_in = 1'b1;
        step(1, 0, 0);
        check("sync_e1", 0, 1, onehot(1), 0, 0);
        step(1, 0, 0);
        check("sync_e2", 0, 1, onehot(1), 0, 0);
        step(1, 0, 0);
        check("sync_e3", 0, 0, onehot(0), 1, 0);
        sync_in = 1'b0;
`endif

        do_reset();
        for (int k = 0; k < 3000; k++) begin
            e = ($urandom_range(0, 9) < 8);
            l = ($urandom_range(0, 19) == 0);
            d = int'($urandom_range(0, 6));
            step(e, l, d);
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
